// File: rtl/modulo_contador_sync_7_bits_descendente_pkg.sv
// Shared constants for the 7-bit descending counter: width and default reload value.
package modulo_contador_sync_7_bits_descendente_pkg;
  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0] RELOAD_DEFAULT = 7'd127;
endpackage

// File: rtl/and_gate_2_inputs.sv
// Two-input AND gate used to build the borrow chain.
module and_gate_2_inputs (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/modulo_ff_t_load_sync.sv
// T flip-flop with synchronous clear, synchronous parallel load and toggle enable.
module modulo_ff_t_load_sync (
  input  logic clock,
  input  logic clear,
  input  logic ld,
  input  logic din,
  input  logic t,
  output logic q
);
  logic q_q;
  logic q_d;

  // Priority below clear: ld > t > hold.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = din;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/modulo_contador_sync_7_bits_descendente.sv
// Synchronous 7-bit down counter from T flip-flops with a chained borrow,
// wrapping to RELOAD_VALUE or saturating at zero.
module modulo_contador_sync_7_bits_descendente
  import modulo_contador_sync_7_bits_descendente_pkg::*;
#(
  parameter logic [CNT_W-1:0] RELOAD_VALUE = RELOAD_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] d,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] q,
  output logic             zero,
  output logic             borrow
);
  logic [CNT_W-1:0] q_w;
  logic [CNT_W-1:0] nq;
  logic [CNT_W-1:0] b;
  logic [CNT_W-1:0] t;
  logic [CNT_W-1:0] din;
  logic             qual;
  logic             count_en;
  logic             ld;

  assign nq   = ~q_w;
  assign b[0] = nq[0];

  // b[i] = b[i-1] & ~q[i]; b[i-1] is the toggle term for bit i.
  for (genvar i = 1; i < CNT_W; i++) begin : g_chain
    and_gate_2_inputs u_and (
      .a (b[i-1]),
      .b (nq[i]),
      .y (b[i])
    );
  end

  assign zero = b[CNT_W-1];
  assign qual = enable & auto_reload & ~load & ~clear;

  and_gate_2_inputs u_borrow (
    .a (zero),
    .b (qual),
    .y (borrow)
  );

  // Toggling is suppressed at zero: the wrap goes through the load path and
  // saturation must not let the all-ones toggle pattern through.
  assign count_en = enable & ~zero;
  assign ld       = load | borrow;
  assign din      = load ? d : RELOAD_VALUE;

  assign t[0] = count_en;
  for (genvar i = 1; i < CNT_W; i++) begin : g_t
    assign t[i] = count_en & b[i-1];
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_ff
    modulo_ff_t_load_sync u_ff (
      .clock (clock),
      .clear (clear),
      .ld    (ld),
      .din   (din[i]),
      .t     (t[i]),
      .q     (q_w[i])
    );
  end

  assign q = q_w;
endmodule

// File: tb/tb_modulo_contador_sync_7_bits_descendente.sv
// Self-checking bench for the 7-bit descending counter, cascade and parameter overrides.
module tb_modulo_contador_sync_7_bits_descendente;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Main instance, default reload 127.
  logic clear = 1'b0, load = 1'b0, enable = 1'b0, auto_reload = 1'b0;
  logic [6:0] d = '0;
  logic [6:0] q;
  logic zero, borrow;

  modulo_contador_sync_7_bits_descendente u_dut (
    .clock(clock), .clear(clear), .load(load), .d(d), .enable(enable),
    .auto_reload(auto_reload), .q(q), .zero(zero), .borrow(borrow)
  );

  // Reload 10 instance.
  logic p_clear = 1'b0, p_load = 1'b0, p_en = 1'b0, p_ar = 1'b0;
  logic [6:0] p_d = '0;
  logic [6:0] p_q;
  logic p_zero, p_borrow;

  modulo_contador_sync_7_bits_descendente #(.RELOAD_VALUE(7'd10)) u_p10 (
    .clock(clock), .clear(p_clear), .load(p_load), .d(p_d), .enable(p_en),
    .auto_reload(p_ar), .q(p_q), .zero(p_zero), .borrow(p_borrow)
  );

  // Reload 0 instance.
  logic z_clear = 1'b0, z_en = 1'b0, z_ar = 1'b0;
  logic [6:0] z_q;
  logic z_zero, z_borrow;

  modulo_contador_sync_7_bits_descendente #(.RELOAD_VALUE(7'd0)) u_p0 (
    .clock(clock), .clear(z_clear), .load(1'b0), .d(7'd0), .enable(z_en),
    .auto_reload(z_ar), .q(z_q), .zero(z_zero), .borrow(z_borrow)
  );

  // Cascade: low borrow drives high enable.
  logic c_clear = 1'b0, c_load = 1'b0, c_en = 1'b0;
  logic [6:0] c_d = '0;
  logic [6:0] lo_q, hi_q;
  logic lo_zero, lo_borrow, hi_zero, hi_borrow;

  modulo_contador_sync_7_bits_descendente u_lo (
    .clock(clock), .clear(c_clear), .load(c_load), .d(c_d), .enable(c_en),
    .auto_reload(1'b1), .q(lo_q), .zero(lo_zero), .borrow(lo_borrow)
  );
  modulo_contador_sync_7_bits_descendente u_hi (
    .clock(clock), .clear(c_clear), .load(c_load), .d(c_d), .enable(lo_borrow),
    .auto_reload(1'b1), .q(hi_q), .zero(hi_zero), .borrow(hi_borrow)
  );

  typedef struct {
    logic       clr;
    logic       ld;
    logic [6:0] d;
    logic       en;
    logic       ar;
    logic       exp_b;  // borrow before the edge
    logic [6:0] exp_q;  // q after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, ld, input logic [6:0] dv, input logic en, ar,
                     input logic eb, input logic [6:0] eq);
    vec_t v;
    v.clr = clr; v.ld = ld; v.d = dv; v.en = en; v.ar = ar; v.exp_b = eb; v.exp_q = eq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [6:0]  mq;
  logic [13:0] exp14;
  int pulses;
  int first_pulse;
  int second_pulse;

  initial begin
    // Reset, hold, saturate.
    add(1, 0, 7'd0, 0, 0, 0, 7'd0);
    add(1, 0, 7'd0, 0, 0, 0, 7'd0);
    add(0, 0, 7'd0, 0, 0, 0, 7'd0);
    for (int i = 0; i < 5; i++) add(0, 0, 7'd0, 1, 0, 0, 7'd0);
    // Load 5 and count down through the wrap.
    add(0, 1, 7'd5, 0, 1, 0, 7'd5);
    add(0, 0, 7'd0, 1, 1, 0, 7'd4);
    add(0, 0, 7'd0, 1, 1, 0, 7'd3);
    add(0, 0, 7'd0, 1, 1, 0, 7'd2);
    add(0, 0, 7'd0, 1, 1, 0, 7'd1);
    add(0, 0, 7'd0, 1, 1, 0, 7'd0);
    add(0, 0, 7'd0, 1, 1, 1, 7'd127);
    add(0, 0, 7'd0, 1, 1, 0, 7'd126);
    // Priority.
    add(0, 1, 7'd40, 0, 1, 0, 7'd40);
    add(1, 1, 7'd9, 1, 1, 0, 7'd0);
    add(0, 1, 7'd9, 1, 1, 0, 7'd9);
    // Load 0 with enable low, then auto_reload decides at the edge.
    add(0, 1, 7'd0, 0, 1, 0, 7'd0);
    add(0, 0, 7'd0, 0, 1, 0, 7'd0);
    add(0, 0, 7'd0, 1, 0, 0, 7'd0);
    add(0, 0, 7'd0, 1, 1, 1, 7'd127);
    // Load and enable together at q=0.
    add(0, 1, 7'd0, 0, 0, 0, 7'd0);
    add(0, 1, 7'd9, 1, 1, 0, 7'd9);
    // Mid-count clear, then resume from 0 with saturate.
    add(0, 0, 7'd0, 1, 1, 0, 7'd8);
    add(1, 0, 7'd0, 1, 1, 0, 7'd0);
    add(0, 0, 7'd0, 1, 0, 0, 7'd0);

    @(negedge clock);
    foreach (vecs[i]) begin
      clear = vecs[i].clr; load = vecs[i].ld; d = vecs[i].d;
      enable = vecs[i].en; auto_reload = vecs[i].ar;
      #1;
      chk($sformatf("vec%0d_borrow", i), {13'd0, borrow}, {13'd0, vecs[i].exp_b});
      tick();
      chk($sformatf("vec%0d_q", i), {7'd0, q}, {7'd0, vecs[i].exp_q});
      chk($sformatf("vec%0d_zero", i), {13'd0, zero}, {13'd0, (vecs[i].exp_q == 7'd0)});
      @(negedge clock);
    end

    // Full-period wrap from 127 over 256 enabled cycles.
    clear = 0; load = 1; d = 7'd127; enable = 0; auto_reload = 1;
    tick(); @(negedge clock);
    load = 0; enable = 1;
    mq = 7'd127; pulses = 0; first_pulse = -1; second_pulse = -1;
    for (int c = 0; c < 256; c++) begin
      #1;
      chk("sweep_borrow", {13'd0, borrow}, {13'd0, (mq == 7'd0)});
      if (borrow) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c; else second_pulse = c;
      end
      tick();
      mq = mq - 7'd1;
      chk("sweep_q", {7'd0, q}, {7'd0, mq});
      @(negedge clock);
    end
    enable = 0;
    chk("sweep_pulses", 14'(pulses), 14'd2);
    chk("sweep_pulse_gap", 14'(second_pulse - first_pulse), 14'd128);

    // Reload 10: count from 3, clear at q=1, then wrap to 10.
    p_clear = 1; tick(); @(negedge clock);
    p_clear = 0; p_load = 1; p_d = 7'd3; tick(); @(negedge clock);
    p_load = 0; p_en = 1; p_ar = 1; tick();
    chk("p10_q2", {7'd0, p_q}, 14'd2);
    @(negedge clock); tick();
    chk("p10_q1", {7'd0, p_q}, 14'd1);
    @(negedge clock); p_clear = 1; tick();
    chk("p10_clear", {7'd0, p_q}, 14'd0);
    @(negedge clock); p_clear = 0; #1;
    chk("p10_borrow", {13'd0, p_borrow}, 14'd1);
    tick();
    chk("p10_reload", {7'd0, p_q}, 14'd10);
    @(negedge clock); tick();
    chk("p10_after", {7'd0, p_q}, 14'd9);
    @(negedge clock); p_en = 0;

    // Reload 0: stays at 0, borrow every enabled cycle.
    z_clear = 1; tick(); @(negedge clock);
    z_clear = 0; z_en = 1; z_ar = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("p0_borrow", {13'd0, z_borrow}, 14'd1);
      tick();
      chk("p0_q", {7'd0, z_q}, 14'd0);
      @(negedge clock);
    end
    z_en = 0;

    // Cascade: both stages loaded with 1, low stage enabled 130 cycles.
    c_clear = 1; tick(); @(negedge clock);
    c_clear = 0; c_load = 1; c_d = 7'd1; tick(); @(negedge clock);
    c_load = 0; c_en = 1;
    exp14 = 14'd129;
    for (int k = 1; k <= 130; k++) begin
      tick();
      exp14 = exp14 - 14'd1;
      chk("cascade_14b", {hi_q, lo_q}, exp14);
      if (k == 2) chk("cascade_hi_k2", {7'd0, hi_q}, 14'd0);
      if (k == 130) chk("cascade_hi_k130", {7'd0, hi_q}, 14'd127);
      @(negedge clock);
    end
    c_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modulo_contador_sync_7_bits_descendente.md
# modulo_contador_sync_7_bits_descendente

Synchronous 7-bit down counter built from T flip-flops and two-input gates, the descending counterpart of the team's 7-bit ascending counter. It counts from a loaded or reload value toward zero, then either wraps to a parameterised reload value or saturates at zero. A combinational borrow output allows stages to be cascaded or to drive timeout and terminal-count logic elsewhere in the design.

## Interface
Parameters:
- RELOAD_VALUE, default 7'd127: value taken on underflow when auto_reload=1.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- clear  input  1  synchronous, active-high reset; highest priority.
- load  input  1  synchronous parallel load of d.
- d  input  7  parallel load value.
- enable  input  1  count-down enable.
- auto_reload  input  1  1 = wrap to RELOAD_VALUE at underflow; 0 = saturate at zero.
- q  output  7  counter state; q[0] is the LSB.
- zero  output  1  combinational; high when q == 0.
- borrow  output  1  combinational terminal count; high when enable=1, q=0, auto_reload=1, load=0, clear=0.

## Operation
- Priority per rising edge: clear > load > enable > hold.
- clear=1: q <= 7'd0. Any load or enable asserted in the same cycle is ignored.
- load=1 (clear=0): q <= d, regardless of enable or auto_reload.
- enable=1 and q != 0: q <= q - 1.
- enable=1, q == 0, auto_reload=1: q <= RELOAD_VALUE. borrow is high during this cycle.
- enable=1, q == 0, auto_reload=0: q holds at 0. borrow stays low.
- enable=0: q holds.
- Decrement is implemented as T logic, not an adder:
  - T0 = 1.
  - Ti = AND(~q[0..i-1]) for i ≥ 1, i.e. chained borrow terms b0 = ~q0, bi = b(i-1) & ~qi.
  - Bit i toggles when enable & Ti.
- Reload and load both force the flip-flop next-state through the synchronous load path. They are never expressed as toggle patterns.
- Cascade rule: borrow of the low stage drives enable of the next stage. The combined count decrements correctly because borrow fires exactly when the low stage wraps.

## Timing
- Reset values: q = 0, zero = 1, borrow = 0 (while clear is held).
- Latency: load, decrement and reload take effect on q one clock after the sampling edge. There is no pipeline.
- zero and borrow are purely combinational from q and the inputs, with zero-cycle latency.
- borrow is high for exactly one clock per wrap when enable is continuous.
- Full sweep with auto_reload=1 and RELOAD_VALUE=127: period of 128 enabled cycles.
- Boundary cases:
  - load of 0 with enable=0: zero=1 next cycle; borrow low until enable is asserted.
  - auto_reload changes while q=0: the value sampled at the edge decides wrap versus saturate.
  - clear asserted mid-count: q = 0 on the next edge. Counting resumes from 0 on release, and the first enabled edge wraps or saturates per auto_reload.
  - load and enable at q=0 in the same cycle: load wins and borrow is low.
  - RELOAD_VALUE=0 with auto_reload=1: q stays 0 and borrow is high every enabled cycle.

## Structure
- Shared constants include file holds the counter width (7) and the default reload value. No other shared types.
- One natural sub-module: modulo_ff_t_load_sync.
  - T flip-flop with synchronous clear, synchronous load (ld, din) and toggle enable.
  - Priority inside the flip-flop: clear > ld > t.
  - Seven instances.
- Borrow chain built from and_gate_2_inputs plus inverters: six two-input ANDs for T1..T6, one more for the borrow output qualifier chain.

## Test plan
- Reset, hold, saturate:
  - Stimulus: clear=1 for 2 cycles, then enable=0.
  - Required: q=0, zero=1, borrow=0.
  - Then enable=1, auto_reload=0 for 5 cycles: q stays 0 and borrow stays 0.
- Load and count down:
  - Stimulus: load d=7'd5, then enable=1, auto_reload=1.
  - Required q sequence: 5,4,3,2,1,0,127,126.
  - Required: borrow high only in the cycle where q=0; zero high only at q=0.
- Full-period wrap:
  - Stimulus: load d=7'd127, enable continuous for 256 cycles.
  - Required: exactly 2 borrow pulses, 128 cycles apart; every transition satisfies q_next = q-1 mod 128.
- Priority:
  - Stimulus: at q=7'd40, assert clear, load (d=9) and enable together.
  - Required: q=0.
  - Next cycle, load (d=9) with enable=1: q=9.
- Cascade:
  - Stimulus: two instances, low-stage borrow driving high-stage enable; both loaded with 7'd1; enable the low stage for 130 cycles.
  - Required high-stage q: 1 → 0 after the 2nd enable, then 127 after the 130th. The 14-bit value decrements monotonically mod 2^14.
- Mid-count reset and parameter override:
  - Stimulus: RELOAD_VALUE=7'd10; count from 3 and assert clear at q=1.
  - Required: q=0. Re-enable with auto_reload=1: next q=10, then 9.
